multicycle_control: RTL and testbench

Multicycle main-control state machine for the MIPS datapath. It decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback. It drives the datapath enables and the ALUOp, Inm and ALUOpFinal inputs consumed by the ALU control decoder. It also stalls on a memory ready handshake.

---
 rtl/multicycle_control_if.sv | 42 ++++
 rtl/multicycle_control.sv | 249 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main controller and the MIPS datapath.
// The controller takes the master side. The datapath takes the slave side and
// supplies the IR opcode and the memory-ready handshake.
interface multicycle_control_if;
    // Inputs to the controller.
    logic [5:0] Opcode;
    logic       mem_ready;

    // ALU-control decoder inputs.
    logic [1:0] ALUOp;
    logic       Inm;
    logic [3:0] ALUOpFinal;

    // Datapath enables and selects.
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic       Illegal;

    modport master (
        input  Opcode, mem_ready,
        output ALUOp, Inm, ALUOpFinal,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
        output IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, Illegal
    );

    modport slave (
        output Opcode, mem_ready,
        input  ALUOp, Inm, ALUOpFinal,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
        input  IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, Illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS main-control FSM: sequences fetch, decode, execute, memory
// and writeback, and drives the datapath enables plus ALUOp/Inm/ALUOpFinal.
// FETCH, MEMRD and MEMWR stall until mem_ready.
// Build option: define IMM_LOGIC_EN to decode andi/ori/slti. Without it those
// opcodes are illegal, and Inm/ALUOpFinal are always 0.
module multicycle_control (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_if.master       bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    // Instruction classes that select the DECODE branch.
    typedef enum logic [2:0] {
        C_MEM,
        C_RTYPE,
        C_BEQ,
        C_JUMP,
        C_IMM,
        C_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // ALU control codes that the immediate logic ops apply directly.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Maps an opcode to the class that selects the DECODE branch.
    function automatic op_class_t classify(input logic [5:0] op);
        op_class_t cls;
        case (op)
            OP_LW, OP_SW: cls = C_MEM;
            OP_RTYPE:     cls = C_RTYPE;
            OP_BEQ:       cls = C_BEQ;
            OP_J:         cls = C_JUMP;
            OP_ADDI:      cls = C_IMM;
`ifdef IMM_LOGIC_EN
            OP_ANDI, OP_ORI, OP_SLTI: cls = C_IMM;
`else
            OP_ANDI, OP_ORI, OP_SLTI: cls = C_ILLEGAL;
`endif
            default:      cls = C_ILLEGAL;
        endcase
        return cls;
    endfunction

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    op_class_t  dec_class;

    // Local copies of the outputs. A single continuous assign per bus signal
    // keeps each interface net driven from exactly one place.
    logic [1:0] alu_op;
    logic       inm;
    logic [3:0] alu_op_final;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic       illegal;

    // Classify the live IR opcode. Only DECODE acts on the result.
    assign dec_class = classify(bus.Opcode);

    // State and latched-opcode registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments, so every flop samples
        // pre-edge values no matter how the blocks are ordered.
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 6'b000000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state sequencing. The opcode is captured only in DECODE.
    always_comb begin
        // NOTE: defaults come first, so no path through the case can leave a
        // variable unassigned and infer a latch.
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = bus.Opcode;
                case (dec_class)
                    C_MEM:   state_d = S_MEMADR;
                    C_RTYPE: state_d = S_REXEC;
                    C_BEQ:   state_d = S_BEQ;
                    C_JUMP:  state_d = S_JUMP;
                    C_IMM:   state_d = S_IEXEC;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_REXEC:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore output decode. The only live-input terms are the FETCH
    // IRWrite/PCWrite qualifier and the DECODE illegal flag.
    always_comb begin
        alu_op        = 2'b00;
        inm           = 1'b0;
        alu_op_final  = 4'b0000;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ior_d         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        pc_source     = 2'b00;
        alu_src_b     = 2'b00;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every cycle. IR and PC commit only once the
                // memory delivers the instruction.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                // The branch target PC + (imm << 2) is computed speculatively.
                alu_src_b = 2'b11;
                illegal   = (dec_class == C_ILLEGAL);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
            end
            S_REXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
`ifdef IMM_LOGIC_EN
                // The logic ops bypass the Funct decode. addi keeps the plain add.
                case (op_q)
                    OP_ANDI: begin inm = 1'b1; alu_op_final = ALU_AND; end
                    OP_ORI:  begin inm = 1'b1; alu_op_final = ALU_OR;  end
                    OP_SLTI: begin inm = 1'b1; alu_op_final = ALU_SLT; end
                    default: begin inm = 1'b0; alu_op_final = 4'b0000; end
                endcase
`endif
            end
            S_IWB: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ALUOp       = alu_op;
    assign bus.Inm         = inm;
    assign bus.ALUOpFinal  = alu_op_final;
    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = ior_d;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.IRWrite     = ir_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.RegWrite    = reg_write;
    assign bus.RegDst      = reg_dst;
    assign bus.PCSource    = pc_source;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.Illegal     = illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. A reference model expands each instruction
// into its expected per-cycle control vectors. The bench then replays that
// plan against the DUT using random mem_ready stalls and random opcode noise
// outside DECODE.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst;
    multicycle_control_if bus();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       inm;
        logic [3:0] alu_op_final;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic       illegal;
    } ctl_t;

    // One expected control step. Steps marked waits repeat while mem_ready is
    // low. In the fetch step, IRWrite and PCWrite follow mem_ready.
    typedef struct {
        ctl_t c;
        bit   waits;
        bit   fetch;
    } step_t;

    typedef enum {K_LW, K_SW, K_R, K_BEQ, K_J, K_ADDI, K_ANDI, K_ORI, K_SLTI, K_ILL} kind_t;

    int    errors = 0;
    int    checks = 0;
    step_t plan[$];

    function automatic kind_t kind_of(input logic [5:0] op);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b001000: return K_ADDI;
`ifdef IMM_LOGIC_EN
            6'b001100: return K_ANDI;
            6'b001101: return K_ORI;
            6'b001010: return K_SLTI;
`endif
            default:   return K_ILL;
        endcase
    endfunction

    function automatic ctl_t observe();
        ctl_t o;
        o.alu_op        = bus.ALUOp;
        o.inm           = bus.Inm;
        o.alu_op_final  = bus.ALUOpFinal;
        o.pc_write      = bus.PCWrite;
        o.pc_write_cond = bus.PCWriteCond;
        o.ior_d         = bus.IorD;
        o.mem_read      = bus.MemRead;
        o.mem_write     = bus.MemWrite;
        o.mem_to_reg    = bus.MemtoReg;
        o.ir_write      = bus.IRWrite;
        o.alu_src_a     = bus.ALUSrcA;
        o.reg_write     = bus.RegWrite;
        o.reg_dst       = bus.RegDst;
        o.pc_source     = bus.PCSource;
        o.alu_src_b     = bus.ALUSrcB;
        o.illegal       = bus.Illegal;
        return o;
    endfunction

    task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input ctl_t c, input bit waits, input bit fetch);
        step_t s;
        s.c = c; s.waits = waits; s.fetch = fetch;
        plan.push_back(s);
    endtask

    // Expected control steps of one instruction, from FETCH to its last cycle.
    task automatic build_plan(input logic [5:0] op);
        kind_t k;
        ctl_t  c;
        k = kind_of(op);
        plan.delete();
        c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
        push(c, 1'b1, 1'b1);
        c = '0; c.alu_src_b = 2'b11; c.illegal = (k == K_ILL);
        push(c, 1'b0, 1'b0);
        case (k)
            K_LW, K_SW: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                push(c, 1'b0, 1'b0);
                if (k == K_LW) begin
                    c = '0; c.mem_read = 1'b1; c.ior_d = 1'b1;
                    push(c, 1'b1, 1'b0);
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                    push(c, 1'b0, 1'b0);
                end else begin
                    c = '0; c.mem_write = 1'b1; c.ior_d = 1'b1;
                    push(c, 1'b1, 1'b0);
                end
            end
            K_R: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b10;
                push(c, 1'b0, 1'b0);
                c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
                push(c, 1'b0, 1'b0);
            end
            K_BEQ: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
                push(c, 1'b0, 1'b0);
            end
            K_J: begin
                c = '0; c.pc_write = 1'b1; c.pc_source = 2'b10;
                push(c, 1'b0, 1'b0);
            end
            K_ADDI, K_ANDI, K_ORI, K_SLTI: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                if (k == K_ANDI) begin c.inm = 1'b1; c.alu_op_final = 4'b0000; end
                if (k == K_ORI)  begin c.inm = 1'b1; c.alu_op_final = 4'b0001; end
                if (k == K_SLTI) begin c.inm = 1'b1; c.alu_op_final = 4'b0111; end
                push(c, 1'b0, 1'b0);
                c = '0; c.reg_write = 1'b1;
                push(c, 1'b0, 1'b0);
            end
            default: ;
        endcase
    endtask

    // Runs one instruction, starting at the negedge before its FETCH cycle.
    //   rand_rdy     : randomise mem_ready (waits capped at 3 cycles)
    //   fetch_stalls : exact number of low mem_ready cycles in FETCH
    //   abort        : assert rst in the first memory-wait cycle, then check IDLE
    task automatic run_instr(input string name, input logic [5:0] op,
                             input bit rand_rdy, input int fetch_stalls,
                             input bit abort);
        build_plan(op);
        for (int i = 0; i < plan.size(); i++) begin
            int   stalls;
            bit   done;
            bit   rdy;
            ctl_t exp;
            stalls = 0;
            done   = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (plan[i].waits && plan[i].fetch && fetch_stalls > 0)
                    rdy = (stalls < fetch_stalls) ? 1'b0 : 1'b1;
                else if (rand_rdy)
                    rdy = (plan[i].waits && stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                else
                    rdy = 1'b1;
                if (abort && plan[i].waits && !plan[i].fetch) begin
                    rdy = 1'b0;
                    rst = 1'b1;
                end
                bus.mem_ready = rdy;
                bus.Opcode    = (i == 1) ? op : 6'($urandom);
                #2;
                exp = plan[i].c;
                if (plan[i].fetch) begin
                    exp.ir_write = rdy;
                    exp.pc_write = rdy;
                end
                check($sformatf("%s step%0d cyc%0d", name, i, stalls), observe(), exp);
                if (rst) begin
                    // The reset edge must leave the controller idle with all
                    // write enables off.
                    @(negedge clk);
                    rst = 1'b0;
                    bus.mem_ready = 1'b0;
                    #2;
                    check($sformatf("%s abort idle", name), observe(), ctl_t'('0));
                    return;
                end
                done = !(plan[i].waits && !rdy);
                stalls++;
            end
        end
    endtask

    // Stops the run if the stimulus ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] legal_ops [9];
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                      6'b001000, 6'b001100, 6'b001101, 6'b001010};

        rst           = 1'b1;
        bus.mem_ready = 1'b0;
        bus.Opcode    = 6'b000000;

        // Two reset cycles. Outputs stay 0 while idle, then FETCH follows.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        check("reset held", observe(), ctl_t'('0));
        rst = 1'b0;
        #1;
        check("reset released idle", observe(), ctl_t'('0));

        // Directed instructions.
        run_instr("lw",       6'b100011, 1'b0, 0, 1'b0);
        run_instr("rtype_st", 6'b000000, 1'b0, 3, 1'b0);
        run_instr("ori",      6'b001101, 1'b0, 0, 1'b0);
        run_instr("andi",     6'b001100, 1'b0, 0, 1'b0);
        run_instr("slti",     6'b001010, 1'b0, 0, 1'b0);
        run_instr("addi",     6'b001000, 1'b0, 0, 1'b0);
        run_instr("beq",      6'b000100, 1'b0, 0, 1'b0);
        run_instr("j",        6'b000010, 1'b0, 0, 1'b0);
        run_instr("ill_3f",   6'b111111, 1'b0, 0, 1'b0);
        run_instr("sw",       6'b101011, 1'b1, 0, 1'b0);
        run_instr("lw_rand",  6'b100011, 1'b1, 0, 1'b0);
        run_instr("sw_abort", 6'b101011, 1'b0, 0, 1'b1);
        run_instr("lw_abort", 6'b100011, 1'b1, 0, 1'b1);

        // Random instruction mix, with some fully random (mostly illegal) opcodes.
        for (int n = 0; n < 40; n++) begin
            int         pick;
            logic [5:0] op;
            pick = $urandom_range(0, 10);
            op   = (pick < 9) ? legal_ops[pick] : 6'($urandom);
            run_instr($sformatf("rnd%0d_op%b", n, op), op, 1'b1, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
